logic32_serial_ctrl: RTL and testbench
======================================

# logic32_serial_ctrl

Multi-cycle 32-bit bitwise logic unit that reuses one narrow logic slice (XOR/AND/OR/NOR) across a 32-bit operand pair, one slice per clock. It trades latency for area, in place of eight parallel 4-bit slices. It sits beside the ALU as a shared logic resource, with a start/busy/done handshake toward the control unit. It contains the operand capture registers, a slice counter, a result shift register and the control FSM.

## Interface

- SLICE_W, default 4: slice width in bits. Legal values are 1, 2, 4 and 8. N_SLICES = 32/SLICE_W.
- clk  input  1  system clock. All state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse. Sampled only in IDLE or DONE.
- op  input  2  operation: 00 XOR, 01 AND, 10 OR, 11 NOR.
- a  input  32  operand A. Captured on accepted start.
- b  input  32  operand B. Captured on accepted start.
- busy  output  1  high while slices are being processed (RUN).
- done  output  1  one-cycle pulse when result is updated.
- result  output  32  last completed result. Held until the next completion.

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 → capture a, b and op into a_sh, b_sh and op_q.
  - cnt←0.
  - Next state RUN.
- RUN, every cycle:
  - Slice = f(op_q, a_sh[SLICE_W-1:0], b_sh[SLICE_W-1:0]).
  - r_sh ← {slice, r_sh[31:SLICE_W]}, a right shift that fills from the top.
  - a_sh and b_sh shift right by SLICE_W.
  - cnt←cnt+1.
- RUN, when cnt==N_SLICES-1:
  - result ← {slice, r_sh[31:SLICE_W]}.
  - Next state DONE.
- DONE:
  - done=1 for exactly this cycle.
  - start=1 → behave as IDLE acceptance, going directly to RUN.
  - Otherwise go to IDLE.
- start in RUN is ignored. No queuing, no error flag.
- a, b and op may change freely after acceptance. Only the captured copies are used.
- NOR is ~(a|b) per slice. All ops are purely bitwise, with no carries between slices.
- cnt width is ceil(log2(N_SLICES)). cnt never wraps past N_SLICES-1 within a job.
- reset_n low, at any time including mid-RUN:
  - State goes to IDLE immediately.
  - busy=0, done=0, result=0.
  - a_sh, b_sh, r_sh and cnt are cleared.
  - The in-flight job is discarded, with no done pulse.
- Reset release: the first start is accepted on the first rising edge with reset_n high.

## Timing

- Reset values: busy=0, done=0, result=32'h0, state IDLE.
- Cycle numbering: edge E0 samples start=1.
- busy is high after E0 through E8 (N_SLICES cycles) and low after E8.
- done is high for the single cycle after E8 (edge N_SLICES). result is valid from that same cycle.
- Latency from start to done is N_SLICES cycles: 8 for SLICE_W=4, 32 for SLICE_W=1.
- Throughput: one job per N_SLICES+1 cycles with start held in DONE, and N_SLICES+2 cycles via IDLE.
- result changes only on the completion edge. It is stable during RUN and shows the previous job's value there.
- busy and done are never high in the same cycle.

## Test plan

- Basic XOR, SLICE_W=4: reset, then start with op=00, a=FFFF0000, b=0F0F0F0F.
  - Required: busy high 8 cycles.
  - Required: done one cycle later, with result=F0F00F0F.
  - Required: result stays F0F00F0F for 20 idle cycles.
- All ops, each job with a/b changed to random values the cycle after start:
  - AND 12345678 & 0F0F0F0F → 02040608.
  - OR A5A5A5A5 | 5A5A5A5A → FFFFFFFF.
  - NOR 0 with 0 → FFFFFFFF.
  - All results must be computed from the captured operands.
- start while busy: pulse start with op=01 at cycles 3 and 5 of a running XOR job.
  - Required: XOR result unaffected.
  - Required: exactly one done.
  - Required: busy returns low after 8 cycles.
- Back-to-back: hold start=1 during the DONE cycle with new operands (op=10, a=0000FFFF, b=FFFF0000).
  - Required: busy re-asserts the next cycle.
  - Required: second done 9 cycles after the first, with result=FFFFFFFF.
- Reset mid-op: assert reset_n=0 asynchronously at RUN cycle 4.
  - Required: busy, done and result go to 0 immediately.
  - Required: no done after release.
  - Required: a fresh XOR job then completes normally in 8 cycles.
- SLICE_W=1 build: XOR 80000001 ^ 00000001 → 80000000 after 32 busy cycles. SLICE_W=8 build: the same vector completes in 4 busy cycles.

Source files
------------

// File: rtl/logic32_serial_ctrl.sv
// Serial 32-bit bitwise logic unit: one SLICE_W-bit XOR/AND/OR/NOR slice
// per clock, with a start/busy/done handshake.
module logic32_serial_ctrl #(
  parameter int SLICE_W = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int N_SLICES = 32 / SLICE_W;
  localparam int CNT_W = $clog2(N_SLICES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SLICES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [31:0]        r_q, r_d;
  logic [31:0]        res_q, res_d;
  logic [1:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SLICE_W-1:0] sa, sb, slice;
  logic [31:0]        r_next;

  assign sa = a_q[SLICE_W-1:0];
  assign sb = b_q[SLICE_W-1:0];

  always_comb begin
    slice = '0;
    unique case (op_q)
      2'b00: slice = sa ^ sb;
      2'b01: slice = sa & sb;
      2'b10: slice = sa | sb;
      2'b11: slice = ~(sa | sb);
      default: slice = '0;
    endcase
  end

  // Result fills from the top so the first slice lands in the LSBs.
  assign r_next = {slice, r_q[31:SLICE_W]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    res_d   = res_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        r_d = r_next;
        a_d = a_q >> SLICE_W;
        b_d = b_q >> SLICE_W;
        if (cnt_q == LAST) begin
          res_d   = r_next;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      res_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      res_q   <= res_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = res_q;

endmodule

// File: tb/tb_logic32_serial_ctrl.sv
// Directed bench for logic32_serial_ctrl: main SLICE_W=4 instance plus
// SLICE_W=1 and SLICE_W=8 instances sharing the same stimulus.
module tb_logic32_serial_ctrl;

  localparam int N = 8;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;
  logic        busy1, done1;
  logic [31:0] result1;
  logic        busy8, done8;
  logic [31:0] result8;

  int total = 0;
  int bad = 0;
  logic [31:0] last_res;

  logic32_serial_ctrl #(.SLICE_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  logic32_serial_ctrl #(.SLICE_W(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .a(a), .b(b), .busy(busy1), .done(done1), .result(result1)
  );

  logic32_serial_ctrl #(.SLICE_W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .a(a), .b(b), .busy(busy8), .done(done8), .result(result8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic job(input logic [1:0] o, input logic [31:0] x, y, ex,
                     input string tag, input bit noise);
    int nb, nd, di, unst;
    nb = 0; nd = 0; di = -1; unst = 0;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    for (int i = 0; i < N + 4; i++) begin
      @(negedge clk);
      if (busy) begin
        nb++;
        if (result !== last_res) unst++;
      end
      if (done) begin
        nd++;
        di = i;
      end
      if (busy && done) unst++;
      start = noise && (i == 2 || i == 4);
      if (noise) op = 2'b01;
    end
    start = 1'b0;
    chk({tag, "_busy"}, nb, N);
    chk({tag, "_ndone"}, nd, 1);
    chk({tag, "_lat"}, di, N);
    chk({tag, "_res"}, result, ex);
    chk({tag, "_hold"}, unst, 0);
    last_res = ex;
  endtask

  initial begin
    int cnt, first, second, bb, d1, d8, nb1, nb8;
    reset_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    last_res = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", result, 32'h0);
    reset_n = 1'b1;

    job(2'b00, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, "xor", 0);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (result !== 32'hF0F00F0F || busy || done) cnt++;
    end
    chk("xor_idle20", cnt, 0);

    job(2'b01, 32'h12345678, 32'h0F0F0F0F, 32'h02040608, "and", 0);
    job(2'b10, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, "or", 0);
    job(2'b11, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, "nor", 0);
    job(2'b00, 32'h12345678, 32'hFFFFFFFF, 32'hEDCBA987, "busystart", 1);

    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'hFFFF0000; b = 32'h0F0F0F0F;
    @(posedge clk);
    #1;
    start = 1'b0;
    first = -1; second = -1; bb = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (first >= 0 && i == first + 1) begin
        bb = busy;
        start = 1'b0;
      end
      if (done) begin
        if (first < 0) begin
          first = i;
          chk("b2b_res1", result, 32'hF0F00F0F);
          start = 1'b1; op = 2'b10;
          a = 32'h0000FFFF; b = 32'hFFFF0000;
        end else if (second < 0) begin
          second = i;
          chk("b2b_res2", result, 32'hFFFFFFFF);
        end
      end
    end
    start = 1'b0;
    chk("b2b_rebusy", bb, 1);
    chk("b2b_gap", second - first, 9);
    last_res = 32'hFFFFFFFF;

    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'h12345678; b = 32'h87654321;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_res", result, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy || result !== 32'h0) cnt++;
    end
    chk("mid_nodone", cnt, 0);
    last_res = 32'h0;
    job(2'b00, 32'h80000001, 32'h00000001, 32'h80000000, "fresh", 0);

    repeat (40) @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'h80000001; b = 32'h00000001;
    @(posedge clk);
    #1;
    start = 1'b0;
    d1 = -1; d8 = -1; nb1 = 0; nb8 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy1) nb1++;
      if (busy8) nb8++;
      if (done1 && d1 < 0) begin
        d1 = i;
        chk("w1_res", result1, 32'h80000000);
      end
      if (done8 && d8 < 0) begin
        d8 = i;
        chk("w8_res", result8, 32'h80000000);
      end
    end
    chk("w1_busy", nb1, 32);
    chk("w1_lat", d1, 32);
    chk("w8_busy", nb8, 4);
    chk("w8_lat", d8, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
